// File: rtl/pmem_loader.sv
// pmem_loader: writer side of the program-memory load port.
// Assembles 12-bit instructions from low/high byte pairs received on a
// valid/ready stream and writes them to addresses 0..PROG_DEPTH-1, then
// holds load_done until the next start.
// Optional build macro PMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
// (running 8-bit sum of all data bytes plus checksum must be 0 mod 256);
// a mismatch sets the sticky err flag and returns to IDLE without load_done.
module pmem_loader #(
  parameter int PROG_DEPTH = 10,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load_en,
  output logic [ADDR_W-1:0] load_addr,
  output logic [11:0]       load_instr,
  output logic              load_done,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_WRITE,
    S_DONE,
    S_CHECK
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] low_byte;
  logic       xfer;
  logic       start_ok;

  // A byte moves only when the state-decoded ready meets the producer's valid.
  assign xfer     = in_valid & in_ready;
  // start is honoured only when no session is running.
  assign start_ok = start & ((state == S_IDLE) | (state == S_DONE));

`ifdef PMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_chk;
  logic       err_q;

  // Sum including the candidate checksum byte; zero means the load is intact.
  assign sum_chk = sum + in_data;
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load_en   = 1'b0;
    load_done = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOW;
      end
      S_LOW: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = S_HIGH;
      end
      S_HIGH: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        load_en = 1'b1;
        busy    = 1'b1;
        if (load_addr == LAST_ADDR) begin
`ifdef PMEM_LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_LOW;
        end
      end
      S_DONE: begin
        load_done = 1'b1;
        if (start) state_nxt = S_LOW;
      end
`ifdef PMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = (sum_chk == 8'd0) ? S_DONE : S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write address and assembled instruction; address advances after each write.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_addr  <= '0;
      load_instr <= '0;
    end else begin
      if (start_ok)
        load_addr <= '0;
      else if ((state == S_WRITE) && (load_addr != LAST_ADDR))
        load_addr <= load_addr + 1'b1;
      if ((state == S_HIGH) && xfer)
        load_instr <= {in_data[3:0], low_byte};
    end
  end

  // Low byte holding register; pure data, needs no reset.
  always_ff @(posedge clk) begin
    if ((state == S_LOW) && xfer) low_byte <= in_data;
  end

`ifdef PMEM_LOADER_CHECKSUM_EN
  // Running byte sum and sticky checksum error.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (start_ok) begin
        sum   <= 8'd0;
        err_q <= 1'b0;
      end else if (((state == S_LOW) || (state == S_HIGH)) && xfer) begin
        sum <= sum + in_data;
      end else if ((state == S_CHECK) && xfer && (sum_chk != 8'd0)) begin
        err_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pmem_loader.sv
// Scoreboard bench for pmem_loader: the stimulus side pushes the expected
// (address, instruction) of every word it sends; a negedge monitor pops and
// compares on every load_en pulse and flags any pulse nobody expected.
`timescale 1ns/1ps
module tb_pmem_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 10;
`ifdef PMEM_LOADER_CHECKSUM_EN
  localparam int DONE_LAT = 2;
`else
  localparam int DONE_LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, load_en, load_done, busy, err;
  logic [ADDR_W-1:0] load_addr;
  logic [11:0]       load_instr;

  always #5 clk = ~clk;

  pmem_loader #(.PROG_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .load_done(load_done), .busy(busy), .err(err)
  );

  int         checks = 0;
  int         failures = 0;
  logic [19:0] exp_q[$];
  int         cyc = 0;
  int         pulse_cnt = 0;
  int         last_pulse = -100;
  bit         spacing_on = 1'b0;
  logic [7:0] bsum;

  // Stream tables (low byte, high byte) and hand-computed instructions.
  logic [7:0]  lo_t [10] = '{8'h00, 8'h01, 8'h20, 8'h00, 8'h30, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0]  hi_t [10] = '{8'h00, 8'h0B, 8'h02, 8'h0B, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [11:0] ins_t[10] = '{12'h000, 12'hB01, 12'h220, 12'hB00, 12'h330,
                             12'h105, 12'h000, 12'h000, 12'h000, 12'h000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every load_en pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (load_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_load_en addr=%0d instr=%h required=no pulse", load_addr, load_instr);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("write_addr", load_addr, e[19:12]);
        check("write_instr", load_instr, e[11:0]);
        if (spacing_on && pulse_cnt > 0) check("pulse_spacing", cyc - last_pulse, 3);
      end
      pulse_cnt++;
      last_pulse = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout actual=in_ready low required=accept");
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_word(input int addr, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [11:0] ins, input int glo, input int ghi);
    exp_q.push_back({8'(addr), ins});
    bsum = bsum + lo + hi;
    send_byte(lo, glo);
    send_byte(hi, ghi);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    bsum      = 8'd0;
    pulse_cnt = 0;
  endtask

  task automatic end_session();
`ifdef PMEM_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = 8'd0 - bsum;
    send_byte(c, 0);
`endif
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, load_done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_load_en"}, load_en, 0);
    check({tag, "_load_addr"}, load_addr, 0);
    check({tag, "_load_instr"}, load_instr, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

`ifdef PMEM_LOADER_CHECKSUM_EN
  // Second instance: single-word load with checksum.
  logic       c_rst, c_start, c_valid, c_ready, c_en, c_done, c_busy, c_err;
  logic [7:0] c_data;
  logic [7:0] c_addr;
  logic [11:0] c_instr;

  pmem_loader #(.PROG_DEPTH(1), .ADDR_W(8)) dut_c (
    .clk(clk), .rst(c_rst), .start(c_start), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_ready), .load_en(c_en), .load_addr(c_addr), .load_instr(c_instr),
    .load_done(c_done), .busy(c_busy), .err(c_err)
  );

  task automatic c_session(input logic [7:0] ck, input logic exp_done, input logic exp_err);
    logic [7:0] bytes[3];
    bytes[0] = 8'h34;
    bytes[1] = 8'h02;
    bytes[2] = ck;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int n;
      c_data  = bytes[i];
      c_valid = 1'b1;
      n = 0;
      while (c_ready !== 1'b1 && n < 10) begin
        if (c_en === 1'b1) check("c_instr", c_instr, 12'h234);
        @(negedge clk);
        n++;
      end
      check("c_byte_accepted", c_ready, 1);
      @(negedge clk);
    end
    c_valid = 1'b0;
    check("c_load_done", c_done, exp_done);
    check("c_err", c_err, exp_err);
    check("c_busy", c_busy, 0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; bsum = 8'd0;
`ifdef PMEM_LOADER_CHECKSUM_EN
    c_rst = 1'b1; c_start = 1'b0; c_valid = 1'b0; c_data = 8'h00;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
`ifdef PMEM_LOADER_CHECKSUM_EN
    c_rst = 1'b0;
`endif
    @(negedge clk);

    // Back-to-back stream: 3-cycle word cadence, done one cycle after last write.
    do_start();
    check("start_busy", busy, 1);
    spacing_on = 1'b1;
    for (int i = 0; i < 10; i++) send_word(i, lo_t[i], hi_t[i], ins_t[i], 0, 0);
    end_session();
    wait_done("full_done");
    check("full_done_latency", cyc - last_pulse, DONE_LAT);
    check("full_done_busy", busy, 0);
    check("full_done_ready", in_ready, 0);
    check("full_pulse_count", pulse_cnt, 10);
    check("full_err", err, 0);
    spacing_on = 1'b0;

    // Restart from DONE, then the same stream with valid gaps.
    do_start();
    check("restart_done_clears", load_done, 0);
    check("restart_busy", busy, 1);
    check("restart_addr", load_addr, 0);
    for (int i = 0; i < 10; i++) send_word(i, lo_t[i], hi_t[i], ins_t[i], (i * 7 + 2) % 6, (i + 3) % 6);
    end_session();
    wait_done("gap_done");
    check("gap_pulse_count", pulse_cnt, 10);

    // Upper nibble of the high byte ignored; start while busy ignored.
    do_start();
    send_word(0, 8'h01, 8'hFB, 12'hB01, 0, 0);
    in_valid = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    check("busy_start_busy", busy, 1);
    check("busy_start_addr", load_addr, 1);
    for (int i = 1; i < 10; i++) send_word(i, lo_t[i], hi_t[i], ins_t[i], 0, 0);
    end_session();
    wait_done("nibble_done");
    check("nibble_pulse_count", pulse_cnt, 10);

    // Reset after the fourth write abandons the session.
    do_start();
    for (int i = 0; i < 4; i++) send_word(i, lo_t[i], hi_t[i], ins_t[i], 0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    in_data  = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("post_reset_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("post_reset_pulses", pulse_cnt, 4);
    do_start();
    send_word(0, 8'h30, 8'h03, 12'h330, 0, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("restart_pulse", pulse_cnt, 1);

`ifdef PMEM_LOADER_CHECKSUM_EN
    c_session(8'hCA, 1'b1, 1'b0);
    c_session(8'hCB, 1'b0, 1'b1);
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pmem_loader.md
Name: pmem_loader

Overview:
- Writer side of the program-memory load port (load enable / load address / load instruction) used by the microcontroller's LOAD state.
- Receives a byte stream on a valid/ready interface and assembles 12-bit instructions from byte pairs.
- Writes each instruction to sequential program-memory addresses 0..PROG_DEPTH-1, then raises load_done so the core can leave LOAD and fetch from PC=0.

Parameters:
- PROG_DEPTH, 10, number of instruction words per load. Legal range 1..2^ADDR_W.
- ADDR_W, 8, width of load_addr.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load session; sampled only in IDLE or DONE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- load_en  output  1  program-memory load enable, one-cycle pulse per word.
- load_addr  output  ADDR_W  program-memory write address.
- load_instr  output  12  instruction word being written.
- load_done  output  1  level; all PROG_DEPTH words written.
- busy  output  1  load session in progress.
- err  output  1  sticky error; always 0 unless the optional feature is compiled in.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; in_ready=0, load_en=0, load_addr=0, load_instr=0, load_done=0, busy=0, err=0; byte sum cleared.
  - Reset wins over every other input.
  - Reset mid-session abandons the session; no further load_en pulses occur until a new start.
- Handshake: a byte transfers on a clk edge where in_valid=1 and in_ready=1. in_ready is decoded from the state register only (Moore) and never depends on in_valid.
- Byte order per word: low byte first gives load_instr[7:0]; high byte second, where in_data[3:0] gives load_instr[11:8] and in_data[7:4] is ignored.
- States:
  - IDLE: in_ready=0, busy=0. start=1 moves to LOW; load_addr<=0, err<=0, busy<=1.
  - LOW: in_ready=1. On transfer, latch low byte and move to HIGH.
  - HIGH: in_ready=1. On transfer, latch high nibble and move to WRITE.
  - WRITE: in_ready=0, load_en=1 for exactly this one cycle; load_addr and load_instr are stable throughout.
    - If load_addr==PROG_DEPTH-1, go to DONE (or CHECK with the optional feature).
    - Otherwise load_addr<=load_addr+1 and go to LOW.
  - DONE: load_done=1 (held), busy=0, in_ready=0. start=1 clears load_done the next cycle and re-enters LOW with load_addr=0.
- Latency and throughput: load_en is asserted in the cycle after the high-byte transfer. Minimum 3 cycles per word with in_valid held high.
- start while busy=1 is ignored.
- load_addr never exceeds PROG_DEPTH-1 and never wraps within a session.
- load_en is never asserted outside WRITE.
- All outputs are registered or decoded from the state register only; no input-to-output combinational path.

Optional Feature:
- Macro: PMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - An 8-bit running sum (mod 256) of every accepted data byte, both bytes of every word, is kept and cleared on start.
  - After the last WRITE, the block enters CHECK with in_ready=1 and accepts one checksum byte.
  - If (sum + checksum byte) mod 256 == 0: go to DONE.
  - Otherwise: err<=1, load_done stays 0, return to IDLE. The core stays in LOAD until a new start.
- Without the macro: no CHECK state, no sum register, err is tied to 0.

Test Plan:
- Reset, start pulse, stream the 20 bytes 00 00, 01 0B, 20 02, 00 0B, 30 03, 05 01, 00 00 x4 with in_valid held high -> 10 load_en pulses at load_addr 0..9 with load_instr 000,B01,220,B00,330,105,000,000,000,000; pulses spaced 3 cycles apart; load_done=1 and busy=0 one cycle after the addr-9 write.
- Same stream with in_valid deasserted on random cycles (gaps up to 5 cycles) -> identical address/instruction sequence, exactly 10 load_en pulses, none during gaps.
- Word bytes 01 FB at address 0 -> load_instr=0xB01 (upper nibble F ignored).
- start asserted again while busy -> no effect. start in DONE -> load_done drops next cycle and the next write lands at load_addr=0.
- rst asserted for 1 cycle after the 4th write -> all outputs at reset values on the next edge; further bytes leave in_ready=0 and produce no load_en until start.
- PMEM_LOADER_CHECKSUM_EN, PROG_DEPTH=1, bytes 34 02, checksum CA -> load_done=1, err=0. Same with checksum CB -> err=1, load_done=0, state IDLE.
